// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed (div) or unsigned (divu).
//
// One quotient bit per cycle; a WIDTH-bit divide takes WIDTH+2 cycles from
// the accepted start to the done pulse. A zero divisor skips the iteration
// and finishes on the next cycle.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      synchronous active-low reset
//   start        request pulse, accepted only while idle
//   is_signed    1 = two's-complement divide, 0 = unsigned
//   dividend     numerator, sampled with the accepted start
//   divisor      denominator, sampled with the accepted start
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     result (LO)
//   remainder    result (HI)
//   div_by_zero  set with done when the latched divisor was zero
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one restoring step per cycle, WIDTH steps in total
// FIX   | apply result signs, load quotient/remainder
// DONE  | done pulse for one cycle, then back to IDLE

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_work;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_work;    // partial remainder
  logic [WIDTH-1:0] dvs_mag;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             dvs_zero, last_step;

  // Magnitudes of the incoming operands; the most-negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  assign dvd_mag_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag_in = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign dvs_zero   = (divisor == '0);

  // Trial subtraction carried at WIDTH+1 bits; bit WIDTH is the borrow.
  assign rem_shift = {r_work, q_work[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_mag};

  assign fix_q = neg_q ? -q_work : q_work;
  assign fix_r = neg_r ? -r_work : r_work;

  assign last_step = (count == CW'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = dvs_zero ? DONE : RUN;
      RUN:  if (last_step) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count       <= '0;
      q_work      <= '0;
      r_work      <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count       <= '0;
            q_work      <= dvd_mag_in;
            r_work      <= '0;
            dvs_mag     <= dvs_mag_in;
            neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= is_signed & dividend[WIDTH-1];
            div_by_zero <= dvs_zero;
            // Zero divisor goes straight to DONE, so results load here.
            if (dvs_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        RUN: begin
          r_work <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          q_work <= {q_work[WIDTH-2:0], ~trial[WIDTH]};
          count  <= count + 1'b1;
        end
        FIX: begin
          quotient  <= fix_q;
          remainder <= fix_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one operation. Cycle 1 is the period right after the accepting
  // edge. If inj > 0, a start with different operands (1000/3 unsigned) is
  // pulsed for one cycle at cycle inj and must be ignored.
  task automatic do_div(input string name, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat, input int inj);
    int cyc, busy_cnt;
    logic got;
    logic [31:0] q_hold, r_hold;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_cnt = 0; got = 1'b0;
    while (cyc < 100 && !got) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      if (cyc == inj) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      end
    end
    check($sformatf("%s.done_seen", name), {31'b0, got}, 32'd1);
    check($sformatf("%s.latency", name), cyc, elat);
    check($sformatf("%s.busy_cycles", name), busy_cnt, cyc);
    check($sformatf("%s.quotient", name), quotient, eq);
    check($sformatf("%s.remainder", name), remainder, er);
    check($sformatf("%s.div_by_zero", name), {31'b0, div_by_zero}, {31'b0, edz});
    q_hold = quotient; r_hold = remainder;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s.done_pulse", name), {31'b0, done}, 32'd0);
    check($sformatf("%s.idle_after", name), {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check($sformatf("%s.q_held", name), quotient, eq);
    check($sformatf("%s.r_held", name), remainder, er);
  endtask

  initial begin
    int done_cnt;
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.quotient", quotient, 32'd0);
    check("rst.remainder", remainder, 32'd0);
    check("rst.dbz", {31'b0, div_by_zero}, 32'd0);
    reset_n = 1'b1;

    do_div("u100_7",      1'b0, 32'd100,      32'd7,          32'd14,       32'd2,        1'b0, 34, 0);
    do_div("s-7_2",       1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 0);
    do_div("s7_-2",       1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 32'd1,        1'b0, 34, 0);
    do_div("u5_0",        1'b0, 32'd5,        32'd0,          32'hFFFFFFFF, 32'd5,        1'b1, 1,  0);
    do_div("s5_0",        1'b1, 32'd5,        32'd0,          32'hFFFFFFFF, 32'd5,        1'b1, 1,  0);
    do_div("s_ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000, 32'd0,        1'b0, 34, 0);
    do_div("uFFFF_1",     1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF, 32'd0,        1'b0, 34, 0);
    do_div("uFFF9_2",     1'b0, 32'hFFFFFFF9, 32'd2,          32'h7FFFFFFC, 32'd1,        1'b0, 34, 0);
    do_div("s1000_3",     1'b1, 32'd1000,     32'd3,          32'd333,      32'd1,        1'b0, 34, 0);
    do_div("midrun_start",1'b0, 32'd100,      32'd7,          32'd14,       32'd2,        1'b0, 34, 5);
    do_div("done_start",  1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 32'd1,        1'b0, 34, 34);

    // Reset at cycle 10 of an operation aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.done", {31'b0, done}, 32'd0);
    check("abort.quotient", quotient, 32'd0);
    check("abort.remainder", remainder, 32'd0);
    check("abort.dbz", {31'b0, div_by_zero}, 32'd0);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort.no_done", done_cnt, 32'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset_n = 1'b0; start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd0;
    @(negedge clk);
    check("rst_prio.busy", {31'b0, busy}, 32'd0);
    check("rst_prio.dbz", {31'b0, div_by_zero}, 32'd0);
    reset_n = 1'b1; start = 1'b0;

    do_div("after_rst",   1'b0, 32'd1000,     32'd3,          32'd333,      32'd1,        1'b0, 34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
